// File: rtl/i2c_protocol_checker.sv
// i2c_protocol_checker
// Samples already-synchronised SCL/SDA on clk and reports START, repeated
// START and STOP as single-cycle pulses. While the bus is busy it frames
// bytes (8 data bits, MSB first, plus the ACK bit) and flags protocol
// violations: STOP while idle, STOP/repeated START in the middle of a byte,
// and a bus that stays busy without any SCL edge for TIMEOUT_CYCLES clocks.
//
// Optional feature macro: I2C_CHK_ERRCNT_EN
//   defined   -> err_count is a saturating counter of error cycles
//   undefined -> no counter flops, err_count is tied to zero
// The sticky error flags are identical in both builds.
//
// A START/STOP needs SCL high on both the previous and current sample, so
// a sample where SCL and SDA change together is treated as an SCL edge only.
// Reset puts scl_q/sda_q at the idle-bus level (1), so the first sample
// after reset is compared against an idle bus.

module i2c_protocol_checker #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16,
   parameter int ERR_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scl,
   input  logic                 sda,
   input  logic                 err_clr,
   output logic                 start_cond,
   output logic                 rstart_cond,
   output logic                 stop_cond,
   output logic                 bus_busy,
   output logic [3:0]           bit_cnt,
   output logic                 byte_done,
   output logic [7:0]           data_byte,
   output logic                 ack_bit,
   output logic                 err_timeout,
   output logic                 err_frame,
   output logic                 err_stray_stop,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Counter value at which a stalled busy bus is declared timed out.
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] TO_ONE   = CNT_W'(1'b1);
   localparam logic [3:0]       BITS_ALL = 4'd8;

   state_t           state_r;
   state_t           state_s;

   logic             scl_q_r;
   logic             sda_q_r;
   logic [7:0]       shreg_r;
   logic [7:0]       shreg_s;
   logic [CNT_W-1:0] to_cnt_r;
   logic [CNT_W-1:0] to_cnt_s;

   logic             scl_rise_s;
   logic             scl_fall_s;
   logic             sda_rise_s;
   logic             sda_fall_s;
   logic             start_ev_s;
   logic             stop_ev_s;

   logic [3:0]       bit_cnt_s;
   logic [7:0]       data_byte_s;
   logic             ack_bit_s;
   logic             start_cond_s;
   logic             rstart_cond_s;
   logic             stop_cond_s;
   logic             byte_done_s;

   logic             ev_timeout_s;
   logic             ev_frame_s;
   logic             ev_stray_s;
   logic             err_timeout_s;
   logic             err_frame_s;
   logic             err_stray_stop_s;

   // Edge and bus-condition decode from the previous and current sample.
   always_comb begin
      scl_rise_s = ~scl_q_r &  scl;
      scl_fall_s =  scl_q_r & ~scl;
      sda_rise_s = ~sda_q_r &  sda;
      sda_fall_s =  sda_q_r & ~sda;
      start_ev_s = scl_q_r & scl & sda_fall_s;
      stop_ev_s  = scl_q_r & scl & sda_rise_s;
   end

   // Next-state, byte framing, timeout counter and error-event decode.
   always_comb begin
      state_s       = state_r;
      bit_cnt_s     = bit_cnt;
      shreg_s       = shreg_r;
      data_byte_s   = data_byte;
      ack_bit_s     = ack_bit;
      to_cnt_s      = to_cnt_r;
      start_cond_s  = 1'b0;
      rstart_cond_s = 1'b0;
      stop_cond_s   = 1'b0;
      byte_done_s   = 1'b0;
      ev_timeout_s  = 1'b0;
      ev_frame_s    = 1'b0;
      ev_stray_s    = 1'b0;

      case (state_r)
         ST_IDLE: begin
            to_cnt_s = TO_ZERO;
            if (start_ev_s) begin
               state_s      = ST_BUSY;
               start_cond_s = 1'b1;
               bit_cnt_s    = 4'd0;
            end else if (stop_ev_s) begin
               stop_cond_s = 1'b1;
               ev_stray_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_BUSY: begin
            if (start_ev_s) begin
               // Repeated START: a partial byte in flight is a framing error.
               rstart_cond_s = 1'b1;
               ev_frame_s    = (bit_cnt != 4'd0);
               bit_cnt_s     = 4'd0;
               to_cnt_s      = TO_ZERO;
            end else if (stop_ev_s) begin
               stop_cond_s = 1'b1;
               ev_frame_s  = (bit_cnt != 4'd0);
               state_s     = ST_IDLE;
               bit_cnt_s   = 4'd0;
               to_cnt_s    = TO_ZERO;
            end else if (scl_rise_s) begin
               to_cnt_s = TO_ZERO;
               if (bit_cnt == BITS_ALL) begin
                  // Ninth clock: shreg holds the data bits, sda is the ACK.
                  bit_cnt_s   = 4'd0;
                  data_byte_s = shreg_r;
                  ack_bit_s   = sda;
                  byte_done_s = 1'b1;
               end else begin
                  shreg_s   = {shreg_r[6:0], sda};
                  bit_cnt_s = bit_cnt + 4'd1;
               end
            end else if (scl_fall_s) begin
               to_cnt_s = TO_ZERO;
            end else if (to_cnt_r == TO_LAST) begin
               // Bus stalled: drop back to idle silently, no STOP reported.
               ev_timeout_s = 1'b1;
               state_s      = ST_IDLE;
               bit_cnt_s    = 4'd0;
               to_cnt_s     = TO_ZERO;
            end else begin
               to_cnt_s = to_cnt_r + TO_ONE;
            end
         end

         default: begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            to_cnt_s  = TO_ZERO;
         end
      endcase
   end

   // Sticky flags: a new event in the same cycle overrides err_clr.
   always_comb begin
      err_timeout_s    = ev_timeout_s | (err_timeout    & ~err_clr);
      err_frame_s      = ev_frame_s   | (err_frame      & ~err_clr);
      err_stray_stop_s = ev_stray_s   | (err_stray_stop & ~err_clr);
   end

   // Sample history, FSM state and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q_r        <= 1'b1;
         sda_q_r        <= 1'b1;
         state_r        <= ST_IDLE;
         shreg_r        <= 8'h00;
         to_cnt_r       <= TO_ZERO;
         start_cond     <= 1'b0;
         rstart_cond    <= 1'b0;
         stop_cond      <= 1'b0;
         bus_busy       <= 1'b0;
         bit_cnt        <= 4'd0;
         byte_done      <= 1'b0;
         data_byte      <= 8'h00;
         ack_bit        <= 1'b0;
         err_timeout    <= 1'b0;
         err_frame      <= 1'b0;
         err_stray_stop <= 1'b0;
      end else begin
         scl_q_r        <= scl;
         sda_q_r        <= sda;
         state_r        <= state_s;
         shreg_r        <= shreg_s;
         to_cnt_r       <= to_cnt_s;
         start_cond     <= start_cond_s;
         rstart_cond    <= rstart_cond_s;
         stop_cond      <= stop_cond_s;
         bus_busy       <= (state_s == ST_BUSY);
         bit_cnt        <= bit_cnt_s;
         byte_done      <= byte_done_s;
         data_byte      <= data_byte_s;
         ack_bit        <= ack_bit_s;
         err_timeout    <= err_timeout_s;
         err_frame      <= err_frame_s;
         err_stray_stop <= err_stray_stop_s;
      end
   end

`ifdef I2C_CHK_ERRCNT_EN
   localparam logic [ERR_CNT_W-1:0] ERR_ZERO = {ERR_CNT_W{1'b0}};
   localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1'b1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

   logic                 any_err_s;
   logic [ERR_CNT_W-1:0] err_count_s;

   // Saturating error-cycle count; at most one increment per cycle.
   always_comb begin
      any_err_s   = ev_timeout_s | ev_frame_s | ev_stray_s;
      err_count_s = err_count;
      if (err_clr) begin
         if (any_err_s) begin
            err_count_s = ERR_ONE;
         end else begin
            err_count_s = ERR_ZERO;
         end
      end else if (any_err_s && (err_count != ERR_MAX)) begin
         err_count_s = err_count + ERR_ONE;
      end else begin
         err_count_s = err_count;
      end
   end

   // Error counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= ERR_ZERO;
      end else begin
         err_count <= err_count_s;
      end
   end
`else
   assign err_count = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_i2c_protocol_checker.sv
// Directed testbench for i2c_protocol_checker (TIMEOUT_CYCLES=16, ERR_CNT_W=2).
module tb_i2c_protocol_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1;
   logic       sda = 1'b1;
   logic       err_clr = 1'b0;
   logic       start_cond, rstart_cond, stop_cond, bus_busy;
   logic [3:0] bit_cnt;
   logic       byte_done;
   logic [7:0] data_byte;
   logic       ack_bit, err_timeout, err_frame, err_stray_stop;
   logic [1:0] err_count;

`ifdef I2C_CHK_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   i2c_protocol_checker #(
      .TIMEOUT_CYCLES(16),
      .CNT_W(16),
      .ERR_CNT_W(2)
   ) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda), .err_clr(err_clr),
      .start_cond(start_cond), .rstart_cond(rstart_cond), .stop_cond(stop_cond),
      .bus_busy(bus_busy), .bit_cnt(bit_cnt), .byte_done(byte_done),
      .data_byte(data_byte), .ack_bit(ack_bit), .err_timeout(err_timeout),
      .err_frame(err_frame), .err_stray_stop(err_stray_stop), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Pulse/byte monitor, sampled mid-cycle.
   int         n_start = 0, n_rstart = 0, n_stop = 0, n_byte = 0, busy_viol = 0;
   logic [7:0] byte_log [0:15];
   logic       ack_log  [0:15];
   logic       prev_busy = 1'b0;

   always @(negedge clk) begin
      if (start_cond === 1'b1) n_start++;
      if (rstart_cond === 1'b1) n_rstart++;
      if (stop_cond === 1'b1) n_stop++;
      if (byte_done === 1'b1) begin
         byte_log[n_byte[3:0]] = data_byte;
         ack_log[n_byte[3:0]]  = ack_bit;
         n_byte++;
      end
      if (rst === 1'b0) begin
         if (start_cond === 1'b1 && bus_busy !== 1'b1) busy_viol++;
         if (bus_busy === 1'b1 && prev_busy !== 1'b1 && start_cond !== 1'b1) busy_viol++;
         if (bus_busy === 1'b0 && prev_busy === 1'b1 && stop_cond !== 1'b1 && err_timeout !== 1'b1) busy_viol++;
      end
      prev_busy = bus_busy;
   end

   logic [22:0] all_outs;
   assign all_outs = {start_cond, rstart_cond, stop_cond, bus_busy, bit_cnt, byte_done,
                      data_byte, ack_bit, err_timeout, err_frame, err_stray_stop, err_count};

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bit: SCL low, set SDA, SCL high and hold (8 clk period).
   task automatic drive_bit(input logic b);
      scl = 1'b0; tick(2);
      sda = b;    tick(2);
      scl = 1'b1; tick(4);
   endtask

   task automatic send_bits(input logic [7:0] d, input int n);
      for (int i = n - 1; i >= 0; i--) drive_bit(d[i]);
   endtask

   // STOP while idle: lower SDA under SCL low, then raise SDA with SCL high.
   task automatic stray_stop(input logic clr);
      scl = 1'b0; tick(2);
      sda = 1'b0; tick(2);
      scl = 1'b1; tick(2);
      sda = 1'b1; err_clr = clr; tick(1);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; scl = 1'b1; sda = 1'b1;
      tick(2);
      checks++; if (all_outs !== 23'd0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs); end
      rst = 1'b0;
      tick(2);
      checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", bus_busy); end
   endtask

   task automatic test_single_byte();
      int s0 = n_start, p0 = n_stop, b0 = n_byte, v0 = busy_viol, r0 = n_rstart;
      sda = 1'b0; tick(1);
      checks++; if ({start_cond, bus_busy} !== 2'b11) begin failures++; $display("FAIL start_pulse: got %b expected 11", {start_cond, bus_busy}); end
      tick(3);
      send_bits(8'hA5, 8);
      checks++; if (bit_cnt !== 4'd8) begin failures++; $display("FAIL bitcnt_8: got %0d expected 8", bit_cnt); end
      drive_bit(1'b0);
      checks++; if ({bit_cnt, data_byte, ack_bit} !== {4'd0, 8'hA5, 1'b0}) begin failures++; $display("FAIL byte_a5: got cnt=%0d data=%h ack=%b expected 0/a5/0", bit_cnt, data_byte, ack_bit); end
      sda = 1'b1; tick(1);
      checks++; if ({stop_cond, bus_busy} !== 2'b10) begin failures++; $display("FAIL stop_pulse: got %b expected 10", {stop_cond, bus_busy}); end
      tick(3);
      checks++; if ({n_start - s0, n_stop - p0, n_byte - b0, n_rstart - r0} !== {32'd1, 32'd1, 32'd1, 32'd0}) begin failures++; $display("FAIL single_pulse_counts: got start=%0d stop=%0d byte=%0d rstart=%0d expected 1/1/1/0", n_start - s0, n_stop - p0, n_byte - b0, n_rstart - r0); end
      checks++; if (busy_viol !== v0) begin failures++; $display("FAIL busy_window: got %0d violations expected 0", busy_viol - v0); end
      checks++; if ({err_timeout, err_frame, err_stray_stop, err_count} !== 5'd0) begin failures++; $display("FAIL single_no_err: got %b expected 0", {err_timeout, err_frame, err_stray_stop, err_count}); end
   endtask

   task automatic test_rstart();
      int b0 = n_byte, r0 = n_rstart, s0 = n_start;
      sda = 1'b0; tick(4);
      send_bits(8'h3C, 8);
      drive_bit(1'b1);
      checks++; if ({data_byte, ack_bit} !== {8'h3C, 1'b1}) begin failures++; $display("FAIL byte_3c_nack: got %h/%b expected 3c/1", data_byte, ack_bit); end
      sda = 1'b0; tick(1);
      checks++; if ({rstart_cond, start_cond, bus_busy} !== 3'b101) begin failures++; $display("FAIL rstart_pulse: got %b expected 101", {rstart_cond, start_cond, bus_busy}); end
      tick(3);
      send_bits(8'h81, 8);
      drive_bit(1'b0);
      checks++; if ({data_byte, ack_bit} !== {8'h81, 1'b0}) begin failures++; $display("FAIL byte_81: got %h/%b expected 81/0", data_byte, ack_bit); end
      sda = 1'b1; tick(4);
      checks++; if ({n_rstart - r0, n_start - s0, n_byte - b0} !== {32'd1, 32'd1, 32'd2}) begin failures++; $display("FAIL rstart_counts: got rstart=%0d start=%0d byte=%0d expected 1/1/2", n_rstart - r0, n_start - s0, n_byte - b0); end
      checks++; if ({byte_log[b0[3:0]], ack_log[b0[3:0]], byte_log[4'(b0 + 1)]} !== {8'h3C, 1'b1, 8'h81}) begin failures++; $display("FAIL byte_log: got %h/%b then %h expected 3c/1 then 81", byte_log[b0[3:0]], ack_log[b0[3:0]], byte_log[4'(b0 + 1)]); end
      checks++; if ({err_frame, bus_busy} !== 2'b00) begin failures++; $display("FAIL rstart_no_frame: got %b expected 00", {err_frame, bus_busy}); end
   endtask

   task automatic test_frame_and_stray();
      sda = 1'b0; tick(4);
      send_bits(8'h0A, 4);
      checks++; if (bit_cnt !== 4'd4) begin failures++; $display("FAIL bitcnt_4: got %0d expected 4", bit_cnt); end
      sda = 1'b1; tick(1);
      checks++; if ({stop_cond, err_frame, bus_busy, bit_cnt} !== {3'b110, 4'd0}) begin failures++; $display("FAIL frame_stop: got %b expected 1100000", {stop_cond, err_frame, bus_busy, bit_cnt}); end
      checks++; if (err_count !== (CNT_EN ? 2'd1 : 2'd0)) begin failures++; $display("FAIL frame_count: got %0d expected %0d", err_count, CNT_EN ? 1 : 0); end
      tick(3);
      stray_stop(1'b0);
      checks++; if ({stop_cond, err_stray_stop, err_frame, bus_busy} !== 4'b1110) begin failures++; $display("FAIL stray_stop: got %b expected 1110", {stop_cond, err_stray_stop, err_frame, bus_busy}); end
      checks++; if (err_count !== (CNT_EN ? 2'd2 : 2'd0)) begin failures++; $display("FAIL stray_count: got %0d expected %0d", err_count, CNT_EN ? 2 : 0); end
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      checks++; if ({err_frame, err_stray_stop, err_count} !== 4'd0) begin failures++; $display("FAIL err_clr: got %b expected 0", {err_frame, err_stray_stop, err_count}); end
   endtask

   task automatic test_timeout();
      int p0 = n_stop;
      int first = 0;
      sda = 1'b0; tick(1);
      checks++; if (start_cond !== 1'b1) begin failures++; $display("FAIL to_start: got %b expected 1", start_cond); end
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (first == 0 && err_timeout === 1'b1) first = k;
      end
      checks++; if (first !== 16) begin failures++; $display("FAIL timeout_cycle: got %0d expected 16", first); end
      checks++; if ({err_timeout, bus_busy, n_stop - p0} !== {2'b10, 32'd0}) begin failures++; $display("FAIL timeout_state: got to=%b busy=%b stops=%0d expected 1/0/0", err_timeout, bus_busy, n_stop - p0); end
      checks++; if (err_count !== (CNT_EN ? 2'd1 : 2'd0)) begin failures++; $display("FAIL timeout_count: got %0d expected %0d", err_count, CNT_EN ? 1 : 0); end
      scl = 1'b0; tick(1);
      sda = 1'b1; tick(1);
      scl = 1'b1; tick(2);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      checks++; if ({err_timeout, err_count} !== 3'd0) begin failures++; $display("FAIL timeout_clr: got %b expected 0", {err_timeout, err_count}); end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 5; i++) begin
         stray_stop(1'b0);
         tick(1);
      end
      checks++; if ({err_stray_stop, err_count} !== {1'b1, (CNT_EN ? 2'd3 : 2'd0)}) begin failures++; $display("FAIL saturate: got flag=%b count=%0d expected 1/%0d", err_stray_stop, err_count, CNT_EN ? 3 : 0); end
      stray_stop(1'b1);
      checks++; if ({err_stray_stop, err_count} !== {1'b1, (CNT_EN ? 2'd1 : 2'd0)}) begin failures++; $display("FAIL clr_vs_event: got flag=%b count=%0d expected 1/%0d", err_stray_stop, err_count, CNT_EN ? 1 : 0); end
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      checks++; if ({err_stray_stop, err_count} !== 3'd0) begin failures++; $display("FAIL sat_clr: got %b expected 0", {err_stray_stop, err_count}); end
      stray_stop(1'b0);
      checks++; if (err_count !== (CNT_EN ? 2'd1 : 2'd0)) begin failures++; $display("FAIL recount: got %0d expected %0d", err_count, CNT_EN ? 1 : 0); end
      tick(2);
   endtask

   task automatic test_simultaneous_and_reset();
      int r0, p0, s0;
      sda = 1'b0; tick(4);
      r0 = n_rstart; p0 = n_stop; s0 = n_start;
      scl = 1'b0; sda = 1'b1; tick(1);
      checks++; if (stop_cond !== 1'b0) begin failures++; $display("FAIL simul_fall_no_stop: got %b expected 0", stop_cond); end
      tick(1);
      scl = 1'b1; sda = 1'b0; tick(1);
      checks++; if ({start_cond, rstart_cond, bit_cnt} !== {2'b00, 4'd1}) begin failures++; $display("FAIL simul_rise_1: got %b expected 000001", {start_cond, rstart_cond, bit_cnt}); end
      tick(1);
      scl = 1'b0; sda = 1'b1; tick(2);
      scl = 1'b1; sda = 1'b0; tick(1);
      checks++; if ({rstart_cond, bit_cnt, bus_busy} !== {1'b0, 4'd2, 1'b1}) begin failures++; $display("FAIL simul_rise_2: got %b expected 000101", {rstart_cond, bit_cnt, bus_busy}); end
      tick(1);
      checks++; if ({n_rstart - r0, n_stop - p0, n_start - s0} !== 96'd0) begin failures++; $display("FAIL simul_no_events: got rstart=%0d stop=%0d start=%0d expected 0", n_rstart - r0, n_stop - p0, n_start - s0); end
      rst = 1'b1; sda = 1'b1; tick(1);
      checks++; if (all_outs !== 23'd0) begin failures++; $display("FAIL midbyte_reset: got %h expected 0", all_outs); end
      rst = 1'b0;
      s0 = n_start; p0 = n_stop;
      tick(3);
      checks++; if ({bus_busy, err_stray_stop, n_start - s0, n_stop - p0} !== {2'b00, 64'd0}) begin failures++; $display("FAIL post_reset_quiet: got busy=%b stray=%b start=%0d stop=%0d expected 0", bus_busy, err_stray_stop, n_start - s0, n_stop - p0); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_rstart();
      test_frame_and_stray();
      test_timeout();
      test_saturate();
      test_simultaneous_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
